// File: rtl/triangle_arb.sv
// rtl/triangle_arb.sv - two-requester round-robin front end for a triangle raster engine
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   req[1:0]            level requests, held until gnt
//   tri_0, tri_1        triangles {x1,y1,x2,y2,x3,y3}, 3 bits each, x1 at [17:15]
//   gnt[1:0]            one-cycle pulse when a triangle is latched
//   done[1:0], cnt      one-cycle finish pulse with the pixel count of that triangle
//   err                 one-cycle pulse on engine timeout
//   eng_nt, eng_xi/yi   vertex load to the engine (nt marks vertex 1)
//   eng_busy            engine busy
//   eng_po, eng_xo/yo   engine pixel output
//   pix_valid, pix_id,  pixel forward, one cycle behind the engine,
//   pix_x, pix_y        tagged with the owning requester
module triangle_arb (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [17:0] tri_0,
  input  logic [17:0] tri_1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic [6:0]  cnt,
  output logic        err,
  output logic        eng_nt,
  output logic [2:0]  eng_xi,
  output logic [2:0]  eng_yi,
  input  logic        eng_busy,
  input  logic        eng_po,
  input  logic [2:0]  eng_xo,
  input  logic [2:0]  eng_yo,
  output logic        pix_valid,
  output logic        pix_id,
  output logic [2:0]  pix_x,
  output logic [2:0]  pix_y
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD1, S_LOAD2, S_LOAD3, S_WAIT, S_DONE
  } state_e;

  state_e      state_q;
  logic        last_q;
  logic        owner_q;
  logic [17:0] tri_q;
  logic [7:0]  tout_q;
  logic [6:0]  pcnt_q;
  logic [6:0]  pcnt_d;
  logic [1:0]  gnt_q;
  logic [1:0]  done_q;
  logic [6:0]  cnt_q;
  logic        err_q;
  logic        eng_nt_q;
  logic [2:0]  eng_xi_q;
  logic [2:0]  eng_yi_q;
  logic        pix_valid_q;
  logic [2:0]  pix_x_q;
  logic [2:0]  pix_y_q;

  logic        win_id;
  logic [17:0] win_tri;
  logic        pix_qual;

  always_comb begin
    win_id   = 1'b0;
    win_tri  = tri_0;
    pix_qual = 1'b0;
    pcnt_d   = pcnt_q;
    // On a tie the requester that was not served last wins.
    if (req == 2'b11) win_id = ~last_q;
    else              win_id = req[1];
    if (win_id) win_tri = tri_1;
    // Only pixels emitted while the engine owns a triangle are forwarded and counted.
    pix_qual = eng_po && ((state_q == S_LOAD3) || (state_q == S_WAIT));
    if (pix_qual && (pcnt_q != 7'd127)) pcnt_d = pcnt_q + 7'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      tri_q       <= '0;
      tout_q      <= '0;
      pcnt_q      <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      eng_nt_q    <= 1'b0;
      eng_xi_q    <= '0;
      eng_yi_q    <= '0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
    end else begin
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      eng_nt_q    <= 1'b0;
      pix_valid_q <= pix_qual;
      pix_x_q     <= eng_xo;
      pix_y_q     <= eng_yo;
      pcnt_q      <= pcnt_d;
      case (state_q)
        S_IDLE: begin
          if ((req != 2'b00) && !eng_busy) begin
            tri_q    <= win_tri;
            owner_q  <= win_id;
            last_q   <= win_id;
            gnt_q    <= win_id ? 2'b10 : 2'b01;
            // Vertex 1 goes out with the grant so it is on the bus during LOAD1.
            eng_nt_q <= 1'b1;
            eng_xi_q <= win_tri[17:15];
            eng_yi_q <= win_tri[14:12];
            pcnt_q   <= '0;
            state_q  <= S_LOAD1;
          end
        end
        S_LOAD1: begin
          eng_xi_q <= tri_q[11:9];
          eng_yi_q <= tri_q[8:6];
          state_q  <= S_LOAD2;
        end
        S_LOAD2: begin
          eng_xi_q <= tri_q[5:3];
          eng_yi_q <= tri_q[2:0];
          state_q  <= S_LOAD3;
        end
        S_LOAD3: begin
          tout_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (!eng_busy) begin
            done_q  <= owner_q ? 2'b10 : 2'b01;
            // pcnt_d so a pixel arriving in this last WAIT cycle is included.
            cnt_q   <= pcnt_d;
            state_q <= S_DONE;
          end else begin
            tout_q <= tout_q + 8'd1;
            // Counter reaches 255 on this edge: abandon the triangle.
            if (tout_q == 8'd254) begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign cnt       = cnt_q;
  assign err       = err_q;
  assign eng_nt    = eng_nt_q;
  assign eng_xi    = eng_xi_q;
  assign eng_yi    = eng_yi_q;
  assign pix_valid = pix_valid_q;
  assign pix_id    = owner_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;

endmodule
